// File: rtl/timer_bus_arbiter.sv
// timer_bus_arbiter
//   Shares the 8-bit timer register port between two requesters:
//     r0 = AVR host bridge
//     r1 = on-chip sequencer
//   Supports narrow (one byte) and atomic wide (two byte) transfers. A wide
//   transfer keeps the port for both bytes, so a 16-bit reload or latch
//   access is never split by the other requester.
//
//   Optional build macro TIMER_ARB_ATOMIC_LATCH_EN:
//     A wide read of the counter pair (addr[2:1] == 00) first strobes the
//     DOLATCH register (address 6). It then reads the latched copy at 4/5.
//     This adds one cycle of latency.
//
// Ports
//   clk, reset              system clock; asynchronous active-high reset
//   rN_req                  request, held as a level
//   rN_we                   1 = write, 0 = read
//   rN_wide                 1 = 16-bit transfer, 0 = 8-bit
//   rN_addr                 timer register address
//   rN_wdata                write data; a narrow transfer uses [7:0]
//   rN_gnt                  one-cycle pulse when the command is latched
//   rN_done                 one-cycle pulse when the transfer completes
//   rdata                   result of the last read transfer
//   t_a, t_d, t_wdstb       registered timer address, write data, write strobe
//   t_O                     timer read data (combinational from t_a)
module timer_bus_arbiter #(
  parameter int PRIO_FIXED = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic        r0_wide,
  input  logic [2:0]  r0_addr,
  input  logic [15:0] r0_wdata,
  output logic        r0_gnt,
  output logic        r0_done,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic        r1_wide,
  input  logic [2:0]  r1_addr,
  input  logic [15:0] r1_wdata,
  output logic        r1_gnt,
  output logic        r1_done,
  output logic [15:0] rdata,
  output logic [2:0]  t_a,
  output logic [7:0]  t_d,
  output logic        t_wdstb,
  input  logic [7:0]  t_O
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LO    = 3'd1;
  localparam logic [2:0] ST_HI    = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
`ifdef TIMER_ARB_ATOMIC_LATCH_EN
  localparam logic [2:0] ST_LATCH = 3'd4;
`endif

  logic [2:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic        wide_q, wide_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        last_q, last_d;     // requester served most recently
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic [15:0] rdata_q, rdata_d;
  logic [2:0]  t_a_q, t_a_d;
  logic [7:0]  t_d_q, t_d_d;
  logic        t_wdstb_q, t_wdstb_d;

  // State and latched-command update
  always_comb begin : next_state
    logic pick;
    pick    = 1'b0;
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    wide_d  = wide_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (r0_req || r1_req) begin
          // On a tie, round-robin gives the port to whoever was not served last
          if (r0_req && r1_req) pick = (PRIO_FIXED != 0) ? 1'b0 : ~last_q;
          else                  pick = r1_req;
          owner_d = pick;
          we_d    = pick ? r1_we    : r0_we;
          wide_d  = pick ? r1_wide  : r0_wide;
          addr_d  = pick ? r1_addr  : r0_addr;
          wdata_d = pick ? r1_wdata : r0_wdata;
          state_d = ST_LO;
`ifdef TIMER_ARB_ATOMIC_LATCH_EN
          if (wide_d && !we_d && (addr_d[2:1] == 2'b00)) state_d = ST_LATCH;
`endif
        end
      end
`ifdef TIMER_ARB_ATOMIC_LATCH_EN
      ST_LATCH: state_d = ST_LO;
`endif
      ST_LO: begin
        if (!we_q) begin
          rdata_d[7:0] = t_O;
          if (!wide_q) rdata_d[15:8] = 8'h00;
        end
        state_d = wide_q ? ST_HI : ST_DONE;
      end
      ST_HI: begin
        if (!we_q) rdata_d[15:8] = t_O;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Port outputs are registered, so they are decoded from the state being
  // entered and the command that will be held there.
  always_comb begin : next_outputs
    logic [1:0] pair;
    pair = addr_d[2:1];
`ifdef TIMER_ARB_ATOMIC_LATCH_EN
    // A latched counter read takes its bytes from the latch copy at 4/5
    if (wide_d && !we_d && (addr_d[2:1] == 2'b00)) pair = 2'b10;
`endif
    t_a_d     = 3'd0;
    t_d_d     = 8'h00;
    t_wdstb_d = 1'b0;
    gnt0_d    = (state_q == ST_IDLE) && (state_d != ST_IDLE) && !owner_d;
    gnt1_d    = (state_q == ST_IDLE) && (state_d != ST_IDLE) &&  owner_d;
    done0_d   = (state_d == ST_DONE) && !owner_d;
    done1_d   = (state_d == ST_DONE) &&  owner_d;
    case (state_d)
`ifdef TIMER_ARB_ATOMIC_LATCH_EN
      ST_LATCH: begin
        t_a_d     = 3'd6;
        t_wdstb_d = 1'b1;
      end
`endif
      ST_LO: begin
        t_a_d = wide_d ? {pair, 1'b0} : addr_d;
        if (we_d) begin
          t_d_d     = wdata_d[7:0];
          t_wdstb_d = 1'b1;
        end
      end
      ST_HI: begin
        t_a_d = {pair, 1'b1};
        if (we_d) begin
          t_d_d     = wdata_d[15:8];
          t_wdstb_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      wide_q    <= 1'b0;
      addr_q    <= 3'd0;
      wdata_q   <= 16'h0000;
      last_q    <= 1'b1;       // r0 wins the first tie
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      rdata_q   <= 16'h0000;
      t_a_q     <= 3'd0;
      t_d_q     <= 8'h00;
      t_wdstb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      wide_q    <= wide_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      last_q    <= last_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      rdata_q   <= rdata_d;
      t_a_q     <= t_a_d;
      t_d_q     <= t_d_d;
      t_wdstb_q <= t_wdstb_d;
    end
  end

  assign r0_gnt  = gnt0_q;
  assign r1_gnt  = gnt1_q;
  assign r0_done = done0_q;
  assign r1_done = done1_q;
  assign rdata   = rdata_q;
  assign t_a     = t_a_q;
  assign t_d     = t_d_q;
  assign t_wdstb = t_wdstb_q;

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// tb_timer_bus_arbiter
//   Scoreboard bench for timer_bus_arbiter.
//   A round-robin instance is attached to a small timer register model.
//   A fixed-priority instance shares the same request inputs.
module tb_timer_bus_arbiter;

  logic        clk, reset;
  logic        r0_req, r0_we, r0_wide, r1_req, r1_we, r1_wide;
  logic [2:0]  r0_addr, r1_addr;
  logic [15:0] r0_wdata, r1_wdata;
  logic        r0_gnt, r0_done, r1_gnt, r1_done, t_wdstb;
  logic [15:0] rdata;
  logic [2:0]  t_a;
  logic [7:0]  t_d, t_O;

  logic        b_r0_gnt, b_r0_done, b_r1_gnt, b_r1_done, b_t_wdstb;
  logic [15:0] b_rdata;
  logic [2:0]  b_t_a;
  logic [7:0]  b_t_d, b_t_o;
  assign b_t_o = 8'h00;

  timer_bus_arbiter #(.PRIO_FIXED(0)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_wide(r0_wide), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_done(r0_done),
    .r1_req(r1_req), .r1_we(r1_we), .r1_wide(r1_wide), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_done(r1_done),
    .rdata(rdata), .t_a(t_a), .t_d(t_d), .t_wdstb(t_wdstb), .t_O(t_O));

  timer_bus_arbiter #(.PRIO_FIXED(1)) dut_fixed (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_wide(r0_wide), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_gnt(b_r0_gnt), .r0_done(b_r0_done),
    .r1_req(r1_req), .r1_we(r1_we), .r1_wide(r1_wide), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_gnt(b_r1_gnt), .r1_done(b_r1_done),
    .rdata(b_rdata), .t_a(b_t_a), .t_d(b_t_d), .t_wdstb(b_t_wdstb), .t_O(b_t_o));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Timer model: counter at 0/1 = 0x01FF, latch copy at 4/5 = 0xBEEF.
  // A write to 6 (DOLATCH) copies the counter into the latch.
  logic [7:0] tregs [8];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) tregs[i] <= 8'h00;
      tregs[0] <= 8'hFF; tregs[1] <= 8'h01;
      tregs[4] <= 8'hEF; tregs[5] <= 8'hBE;
      tregs[6] <= 8'hC5;
    end else if (t_wdstb) begin
      if (t_a == 3'd6) begin
        tregs[4] <= tregs[0];
        tregs[5] <= tregs[1];
      end else begin
        tregs[t_a] <= t_d;
      end
    end
  end
  assign t_O = tregs[t_a];

  // kind: 0 = grant, 1 = strobe, 2 = done; rel = cycle counted from grant (grant = 1)
  typedef struct {int kind; int who; int a; int d; int rd; int rel;} exp_t;
  exp_t q[$];
  int   qb[$];
  int   total = 0, bad = 0, rel = 0, done_cnt = 0;
  bit   chk_b = 0;

  function automatic void ex(input int kind, input int who, input int a,
                             input int d, input int rd, input int r);
    exp_t e;
    e.kind = kind; e.who = who; e.a = a; e.d = d; e.rd = rd; e.rel = r;
    q.push_back(e);
  endfunction

  task automatic sb_check(input int kind, input int who, input int a,
                          input int d, input int rd);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event got kind=%0d who=%0d a=%0d d=%02h rdata=%04h rel=%0d need none",
               kind, who, a, d, rd, rel);
      return;
    end
    e = q.pop_front();
    if (e.kind != kind || e.who != who || e.a != a || e.d != d || e.rd != rd || e.rel != rel) begin
      bad++;
      $display("FAIL event got kind=%0d who=%0d a=%0d d=%02h rdata=%04h rel=%0d need kind=%0d who=%0d a=%0d d=%02h rdata=%04h rel=%0d",
               kind, who, a, d, rd, rel, e.kind, e.who, e.a, e.d, e.rd, e.rel);
    end else begin
      $display("ok event kind=%0d who=%0d a=%0d d=%02h rdata=%04h rel=%0d", kind, who, a, d, rd, rel);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      rel++;
      if (r0_gnt || r1_gnt) rel = 1;
      if (r0_gnt)  sb_check(0, 0, 0, 0, 0);
      if (r1_gnt)  sb_check(0, 1, 0, 0, 0);
      if (t_wdstb) sb_check(1, 0, int'(t_a), int'(t_d), 0);
      if (r0_done) begin sb_check(2, 0, 0, 0, int'(rdata)); done_cnt++; end
      if (r1_done) begin sb_check(2, 1, 0, 0, int'(rdata)); done_cnt++; end
      if (chk_b && (b_r0_gnt || b_r1_gnt)) begin
        total++;
        if (qb.size() == 0) begin
          bad++;
          $display("FAIL fixed_grant got r1=%0b need none", b_r1_gnt);
        end else begin
          int w;
          w = qb.pop_front();
          if (int'(b_r1_gnt) != w || b_r0_gnt == b_r1_gnt) begin
            bad++;
            $display("FAIL fixed_grant got r0=%0b r1=%0b need owner %0d", b_r0_gnt, b_r1_gnt, w);
          end else $display("ok fixed_grant owner %0d", w);
        end
      end
    end
  end

  task automatic drive(input int who, input bit req, input bit we, input bit wide,
                       input logic [2:0] addr, input logic [15:0] wd);
    if (who == 0) begin r0_req = req; r0_we = we; r0_wide = wide; r0_addr = addr; r0_wdata = wd; end
    else          begin r1_req = req; r1_we = we; r1_wide = wide; r1_addr = addr; r1_wdata = wd; end
  endtask

  // Raise req, hold it until granted, scramble the inputs, then wait for done
  task automatic issue(input int who, input bit we, input bit wide,
                       input logic [2:0] addr, input logic [15:0] wd);
    int  d0;
    bit  got;
    d0  = done_cnt;
    got = 0;
    @(negedge clk);
    drive(who, 1'b1, we, wide, addr, wd);
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if ((who == 0) ? r0_gnt : r1_gnt) got = 1;
    end
    drive(who, 1'b0, ~we, ~wide, ~addr, ~wd);
    if (!got) begin
      total++; bad++;
      $display("FAIL grant_timeout got no gnt need r%0d_gnt", who);
      return;
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); #1;
      if (done_cnt > d0) got = 1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL done_timeout got no done need r%0d_done", who);
    end
  endtask

  initial begin
    int  d0;
    bit  got;
    reset = 1'b1;
    drive(0, 0, 0, 0, 3'd0, 16'h0);
    drive(1, 0, 0, 0, 3'd0, 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1;
    total++;
    if ({r0_gnt, r1_gnt, r0_done, r1_done, t_wdstb, t_a, t_d, rdata} != 33'd0) begin
      bad++;
      $display("FAIL reset_state got gnt=%0b%0b done=%0b%0b stb=%0b a=%0d d=%02h rdata=%04h need all 0",
               r0_gnt, r1_gnt, r0_done, r1_done, t_wdstb, t_a, t_d, rdata);
    end else $display("ok reset_state");

    // Narrow write r0 addr 7 = 0x80
    ex(0, 0, 0, 0, 0, 1); ex(1, 0, 7, 8'h80, 0, 1); ex(2, 0, 0, 0, 16'h0000, 2);
    issue(0, 1, 0, 3'd7, 16'h0080);
    // Wide write r1 addr 2 = 0x1234
    ex(0, 1, 0, 0, 0, 1); ex(1, 0, 2, 8'h34, 0, 1); ex(1, 0, 3, 8'h12, 0, 2);
    ex(2, 1, 0, 0, 16'h0000, 3);
    issue(1, 1, 1, 3'd2, 16'h1234);
    // Wide read addr 4 returns the latch copy
    ex(0, 0, 0, 0, 0, 1); ex(2, 0, 0, 0, 16'hBEEF, 3);
    issue(0, 0, 1, 3'd4, 16'h0);
    // Narrow read addr 6 gives a zero-extended result
    ex(0, 1, 0, 0, 0, 1); ex(2, 1, 0, 0, 16'h00C5, 2);
    issue(1, 0, 0, 3'd6, 16'h0);
    // Wide counter read
    ex(0, 0, 0, 0, 0, 1);
`ifdef TIMER_ARB_ATOMIC_LATCH_EN
    ex(1, 0, 6, 0, 0, 1); ex(2, 0, 0, 0, 16'h01FF, 4);
`else
    ex(2, 0, 0, 0, 16'h01FF, 3);
`endif
    issue(0, 0, 1, 3'd0, 16'h0);
    // Wide write at odd addr 3 is aligned down to 2/3; rdata is unchanged
    ex(0, 1, 0, 0, 0, 1); ex(1, 0, 2, 8'h5A, 0, 1); ex(1, 0, 3, 8'hA5, 0, 2);
    ex(2, 1, 0, 0, 16'h01FF, 3);
    issue(1, 1, 1, 3'd3, 16'hA55A);

    // Both held: round-robin alternates 0,1,0,1; fixed priority always picks r0
    for (int k = 0; k < 2; k++) begin
      ex(0, 0, 0, 0, 0, 1); ex(2, 0, 0, 0, 16'h0080, 2);
      ex(0, 1, 0, 0, 0, 1); ex(2, 1, 0, 0, 16'h00C5, 2);
    end
    for (int k = 0; k < 4; k++) qb.push_back(0);
    d0 = done_cnt; got = 0;
    @(negedge clk);
    chk_b = 1;
    drive(0, 1, 0, 0, 3'd7, 16'h0);
    drive(1, 1, 0, 0, 3'd6, 16'h0);
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk); #1;
      if (done_cnt >= d0 + 4) got = 1;
    end
    drive(0, 0, 0, 0, 3'd0, 16'h0);
    drive(1, 0, 0, 0, 3'd0, 16'h0);
    if (!got) begin
      total++; bad++;
      $display("FAIL alternate_timeout got %0d dones need 4", done_cnt - d0);
    end
    repeat (3) @(negedge clk);
    chk_b = 0;

    // Reset during the high byte of a wide write aborts it
    ex(0, 0, 0, 0, 0, 1); ex(1, 0, 0, 8'h77, 0, 1);
    got = 0;
    @(negedge clk);
    drive(0, 1, 1, 1, 3'd0, 16'h7777);
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (r0_gnt) got = 1;
    end
    drive(0, 0, 0, 0, 3'd0, 16'h0);
    if (!got) begin
      total++; bad++;
      $display("FAIL abort_grant_timeout got no gnt need r0_gnt");
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    total++;
    if ({r0_gnt, r1_gnt, r0_done, r1_done, t_wdstb, t_a, t_d, rdata} != 33'd0) begin
      bad++;
      $display("FAIL abort_reset got gnt=%0b%0b done=%0b%0b stb=%0b a=%0d d=%02h rdata=%04h need all 0",
               r0_gnt, r1_gnt, r0_done, r1_done, t_wdstb, t_a, t_d, rdata);
    end else $display("ok abort_reset");
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    // A narrow r1 read after the abort completes normally
    ex(0, 1, 0, 0, 0, 1); ex(2, 1, 0, 0, 16'h00C5, 2);
    issue(1, 0, 0, 3'd6, 16'h0);
    repeat (4) @(negedge clk);

    total++;
    if (q.size() != 0 || qb.size() != 0) begin
      bad++;
      $display("FAIL leftover got %0d/%0d pending need 0/0", q.size(), qb.size());
    end else $display("ok leftover none");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish need finish");
    $fatal(1, "watchdog");
  end

endmodule
